cla_mp_sequencer: RTL and testbench

- Multi-precision adder sequencer. Adds two NWORDS*WIDTH-bit operands by time-multiplexing one WIDTH-bit combinational carry-lookahead adder slice, least significant word first.
- The carry-out of each word is registered and fed back as the carry-in of the next word.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- With the default parameters it is a 64-bit adder built from the team's 16-bit CLA.

---
 rtl/cla_mp_sequencer_if.sv | 40 ++++
 rtl/cla_mp_sequencer.sv | 150 +++++++++++++++
 tb/tb_cla_mp_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_mp_sequencer_if.sv
// Operand/result handshake bundle for cla_mp_sequencer.
// op_sub exists only when CLA_MP_SUB_EN is defined.
interface cla_mp_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 4
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [NWORDS*WIDTH-1:0] a;
  logic [NWORDS*WIDTH-1:0] b;
  logic                    cin;
`ifdef CLA_MP_SUB_EN
  logic                    op_sub;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [NWORDS*WIDTH-1:0] sum;
  logic                    cout;
  logic                    ovf;

`ifdef CLA_MP_SUB_EN
  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/cla_mp_sequencer.sv
// Multi-precision adder: one WIDTH-bit Kogge-Stone CLA slice reused for NWORDS words, LSW first.
// Define CLA_MP_SUB_EN to add the op_sub input (a - b via inverted B and forced carry-in).
module cla_mp_sequencer #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_mp_sequencer_if.slave    bus,
  output logic                 busy
);
  localparam int TOTAL  = NWORDS * WIDTH;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [TOTAL-1:0]   a_reg;
  logic [TOTAL-1:0]   b_reg;
  logic               carry_reg;
  logic [KW-1:0]      k_reg;
  logic               cout_reg;
  logic               ovf_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               in_ready_reg;
  logic [WIDTH-1:0]   sum_word_reg [0:NWORDS-1];

  logic [WIDTH-1:0]   a_words [0:NWORDS-1];
  logic [WIDTH-1:0]   b_words [0:NWORDS-1];
  logic [WIDTH-1:0]   a_word;
  logic [WIDTH-1:0]   b_word;
  logic [WIDTH-1:0]   s_word;
  logic               c_word;
  logic               sub_in;

`ifdef CLA_MP_SUB_EN
  assign sub_in = bus.op_sub;
`else
  assign sub_in = 1'b0;
`endif

  genvar gi;
  for (gi = 0; gi < NWORDS; gi++) begin : g_word
    assign a_words[gi] = a_reg[gi*WIDTH +: WIDTH];
    assign b_words[gi] = b_reg[gi*WIDTH +: WIDTH];
    assign bus.sum[gi*WIDTH +: WIDTH] = sum_word_reg[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_word_reg[gi] <= '0;
      end else if (state_reg == RUN && k_reg == KW'(gi)) begin
        sum_word_reg[gi] <= s_word;
      end
    end
  end

  assign a_word = a_words[k_reg];
  assign b_word = b_words[k_reg];

  // Carry-in is folded into bit 0's generate, so the prefix G[i:0] is directly the carry into bit i+1.
  always_comb begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] carries;
    g      = a_word & b_word;
    p      = a_word ^ b_word;
    g[0]   = g[0] | (p[0] & carry_reg);
    g_next = g;
    p_next = p;
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << lv)) begin
          g_next[i] = g[i] | (p[i] & g[i - (1 << lv)]);
          p_next[i] = p[i] & p[i - (1 << lv)];
        end else begin
          g_next[i] = g[i];
          p_next[i] = p[i];
        end
      end
      g = g_next;
      p = p_next;
    end
    carries = {g[WIDTH-2:0], carry_reg};
    s_word  = (a_word ^ b_word) ^ carries;
    c_word  = g[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      k_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg        <= bus.a;
            b_reg        <= sub_in ? ~bus.b : bus.b;
            carry_reg    <= sub_in | bus.cin;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          carry_reg <= c_word;
          if (k_reg == K_LAST) begin
            // a_word/b_word are the top words here, b already inverted for subtraction.
            cout_reg      <= c_word;
            ovf_reg       <= (a_word[WIDTH-1] == b_word[WIDTH-1]) &&
                             (s_word[WIDTH-1] != a_word[WIDTH-1]);
            k_reg         <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign busy          = busy_reg;
endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Randomized + directed bench for cla_mp_sequencer against a plain-arithmetic reference model.
module tb_cla_mp_sequencer;
  localparam int W = 16;
  localparam int N = 4;
  localparam int T = W * N;

  logic clk;
  logic rst;
  logic busy;
  int   n_pass;
  int   n_total;
  int   n_txn;

  logic [T-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;
  logic [T-1:0] cur_a;
  logic [T-1:0] cur_b;
  logic         cur_cin;
  logic         cur_sub;

  cla_mp_sequencer_if #(.WIDTH(W), .NWORDS(N)) bus ();

  cla_mp_sequencer #(.WIDTH(W), .NWORDS(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [T-1:0] got, input logic [T-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Full-width arithmetic: returns {ovf, cout, sum}.
  function automatic logic [T+1:0] model(input logic [T-1:0] a, input logic [T-1:0] b,
                                         input logic cin, input logic sub);
    logic [T-1:0] bb;
    logic [T:0]   r;
    logic         c0;
    logic         ov;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {{T{1'b0}}, c0};
    ov = (a[T-1] == bb[T-1]) && (r[T-1] != a[T-1]);
    return {ov, r};
  endfunction

  function automatic logic [T-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive_operands(input logic [T-1:0] a, input logic [T-1:0] b,
                                input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef CLA_MP_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("note: subtraction requested without CLA_MP_SUB_EN");
`endif
  endtask

  task automatic set_expect(input logic [T-1:0] a, input logic [T-1:0] b,
                            input logic cin, input logic sub);
    logic [T+1:0] r;
    r = model(a, b, cin, sub);
    cur_a = a; cur_b = b; cur_cin = cin; cur_sub = sub;
    exp_sum  = r[T-1:0];
    exp_cout = r[T];
    exp_ovf  = r[T+1];
  endtask

  // Waits for in_ready, performs the handshake; returns just after the capture edge.
  task automatic send(input logic [T-1:0] a, input logic [T-1:0] b,
                      input logic cin, input logic sub);
    int n;
    set_expect(a, b, cin, sub);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", T'(bus.in_ready), T'(1));
    drive_operands(a, b, cin, sub);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("busy_run", T'(busy), T'(1));
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", T'(lat), T'(N));
    check("sum", bus.sum, exp_sum);
    check("cout", T'(bus.cout), T'(exp_cout));
    check("ovf", T'(bus.ovf), T'(exp_ovf));
    check("in_ready_done", T'(bus.in_ready), T'(0));
    n_txn++;
    $display("txn %0d a=%h b=%h cin=%0d sub=%0d sum=%h cout=%0d ovf=%0d", n_txn, cur_a, cur_b,
             cur_cin, cur_sub, bus.sum, bus.cout, bus.ovf);
  endtask

  // Accept the result; in_valid may stay high over the accept edge and must not be taken.
  task automatic release_result(input int stall);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_sum", bus.sum, exp_sum);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("released_valid", T'(bus.out_valid), T'(0));
    check("released_ready", T'(bus.in_ready), T'(1));
  endtask

  task automatic run_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic cin,
                        input logic sub, input int stall, input logic hold);
    send(a, b, cin, sub);
    if (hold) begin
      drive_operands(rand_word(), rand_word(), 1'b1, 1'b0);
      bus.in_valid = 1'b1;
    end
    wait_result();
    release_result(stall);
  endtask

  initial begin
    logic [T-1:0] held_sum;
    logic [T-1:0] ra;
    logic [T-1:0] rb;
    logic         rsub;
    n_pass = 0; n_total = 0; n_txn = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_operands('0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", T'(bus.in_ready), T'(1));
    check("rst_out_valid", T'(bus.out_valid), T'(0));
    check("rst_busy", T'(busy), T'(0));
    check("rst_sum", bus.sum, '0);
    check("rst_cout", T'(bus.cout), T'(0));
    check("rst_ovf", T'(bus.ovf), T'(0));

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0);
    check("wrap_sum", bus.sum, 64'h0);
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 1, 1'b0);
    check("carry_sum", bus.sum, 64'h0001_0000_0001_0001);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0);
    check("ovf_flag", T'(bus.ovf), T'(1));

    // Backpressure with the next operands already pending on the input side.
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    wait_result();
    held_sum = exp_sum;
    ra = rand_word();
    rb = rand_word();
    drive_operands(ra, rb, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", T'(bus.in_ready), T'(0));
      check("bp_sum", bus.sum, held_sum);
      check("bp_valid", T'(bus.out_valid), T'(1));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_ready", T'(bus.in_ready), T'(1));
    check("bp_idle_valid", T'(bus.out_valid), T'(0));
    set_expect(ra, rb, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_accept", T'(busy), T'(1));
    wait_result();
    release_result(0);

    // Reset during the second RUN cycle discards the operation.
    send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", T'(bus.in_ready), T'(1));
    check("mid_rst_valid", T'(bus.out_valid), T'(0));
    check("mid_rst_busy", T'(busy), T'(0));
    check("mid_rst_sum", bus.sum, '0);
    run_op(64'h3, 64'h4, 1'b0, 1'b0, 0, 1'b0);
    check("post_rst_sum", bus.sum, 64'h7);

`ifdef CLA_MP_SUB_EN
    run_op(64'h5, 64'h7, 1'b1, 1'b1, 0, 1'b0);
    check("sub_neg", bus.sum, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'h7, 64'h5, 1'b0, 1'b1, 0, 1'b0);
    check("sub_pos", bus.sum, 64'h2);
`endif

    for (int t = 0; t < 40; t++) begin
      ra = rand_word();
      rb = rand_word();
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: ra = {1'b0, {(T-1){1'b1}}};
        2: ra = {1'b1, {(T-1){1'b0}}};
        default: ;
      endcase
`ifdef CLA_MP_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), rsub, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
